frame_buffer: RTL and testbench

FRAME_BUFFER -- requirements
Module: frame_buffer

---
 rtl/frame_buffer.sv | 176 +++++++++++++++++
 tb/tb_frame_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer.sv
// Overlapping-frame buffer for a MEMS audio front end: pre-emphasizes incoming
// samples into a circular RAM and streams FRAME_LEN-word frames every HOP samples.
module frame_buffer #(
  parameter int BWIDTH    = 16,
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int ADDR_W    = 9,
  parameter int PE_SHIFT  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [BWIDTH-1:0] din,
  input  logic                     din_dv,
  output logic signed [BWIDTH-1:0] dout,
  output logic                     dout_dv,
  input  logic                     dout_rdy,
  output logic                     sof,
  output logic                     eof,
  output logic                     ovf
);

  localparam int unsigned EW    = BWIDTH + 2;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = $clog2(FRAME_LEN + HOP);
  localparam int unsigned IW    = $clog2(FRAME_LEN);
  localparam int          SAT_MAX = (1 << (BWIDTH - 1)) - 1;
  localparam int          SAT_MIN = -(1 << (BWIDTH - 1));

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  logic signed [BWIDTH-1:0] mem [DEPTH];

  logic signed [BWIDTH-1:0] xp_q, y_q, y_sat_c, dout_q;
  logic signed [EW-1:0]     din_e_c, xp_e_c, y_w_c;
  logic                     wr_en_q, primed_q;
  logic [ADDR_W-1:0]        wr_ptr_q, due_base_c, base_q, pend_base_q, rd_addr_c;
  logic [CW-1:0]            cnt_q;
  logic [IW-1:0]            idx_q;
  logic                     due_c, xfer_c, last_c, rd_en_c, take_pend_c;
  logic                     pend_q, dv_q, sof_q, eof_q, ovf_q;
  state_t                   state_q;

  // y = din - (xp - xp*2^-PE_SHIFT), widened so the subtraction cannot wrap
  always_comb begin
    din_e_c = EW'(din);
    xp_e_c  = EW'(xp_q);
    y_w_c   = din_e_c - (xp_e_c - (xp_e_c >>> PE_SHIFT));
    y_sat_c = BWIDTH'(y_w_c);
    if (y_w_c > EW'(SAT_MAX))      y_sat_c = BWIDTH'(SAT_MAX);
    else if (y_w_c < EW'(SAT_MIN)) y_sat_c = BWIDTH'(SAT_MIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xp_q    <= '0;
      y_q     <= '0;
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= din_dv;
      if (din_dv) begin
        y_q  <= y_sat_c;
        xp_q <= din;
      end
    end
  end

  // First frame after FRAME_LEN writes, then one every HOP writes; counter restarts per frame
  always_comb begin
    due_c      = wr_en_q && (primed_q ? (cnt_q == CW'(HOP - 1)) : (cnt_q == CW'(FRAME_LEN - 1)));
    due_base_c = wr_ptr_q + ADDR_W'(1) - ADDR_W'(FRAME_LEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else if (wr_en_q) begin
      wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (due_c) begin
        cnt_q    <= '0;
        primed_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_ptr_q] <= y_q;
  end

  // RAM is read only on FETCH or a transfer, so dout holds during stalls even if overwritten
  always_comb begin
    xfer_c      = (state_q == STREAM) && dout_rdy;
    last_c      = (idx_q == IW'(FRAME_LEN - 1));
    rd_en_c     = (state_q == FETCH) || xfer_c;
    rd_addr_c   = (state_q == FETCH) ? base_q : base_q + ADDR_W'(idx_q) + ADDR_W'(1);
    take_pend_c = pend_q && ((state_q == IDLE) || (xfer_c && last_c));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
      dout_q      <= '0;
      dv_q        <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (rd_en_c) dout_q <= mem[rd_addr_c];

      if (take_pend_c) begin
        pend_q      <= due_c;
        pend_base_q <= due_base_c;
      end else if (due_c && (state_q != IDLE)) begin
        if (pend_q) begin
          ovf_q <= 1'b1;
        end else begin
          pend_q      <= 1'b1;
          pend_base_q <= due_base_c;
        end
      end

      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_q <= FETCH;
            base_q  <= pend_base_q;
          end else if (due_c) begin
            state_q <= FETCH;
            base_q  <= due_base_c;
          end
        end
        FETCH: begin
          state_q <= STREAM;
          idx_q   <= '0;
          dv_q    <= 1'b1;
          sof_q   <= 1'b1;
          eof_q   <= (FRAME_LEN == 1);
        end
        STREAM: begin
          if (xfer_c) begin
            if (last_c) begin
              dv_q  <= 1'b0;
              sof_q <= 1'b0;
              eof_q <= 1'b0;
              if (pend_q) begin
                state_q <= FETCH;
                base_q  <= pend_base_q;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
              sof_q <= 1'b0;
              eof_q <= (idx_q == IW'(FRAME_LEN - 2));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout    = dout_q;
  assign dout_dv = dv_q;
  assign sof     = sof_q;
  assign eof     = eof_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: table vectors for pre-emphasis, directed frame/overflow/reset
// sequences, and randomized traffic checked against a sample-indexed frame model.
module tb_frame_buffer;

  localparam int FL = 256;
  localparam int HP = 128;

  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] din;
  logic din_dv, dout_rdy;
  logic signed [15:0] dout;
  logic dout_dv, sof, eof, ovf;

  always #5 clk = ~clk;

  frame_buffer #(.BWIDTH(16), .FRAME_LEN(FL), .HOP(HP), .ADDR_W(9), .PE_SHIFT(5)) dut (
    .clk(clk), .reset(reset), .din(din), .din_dv(din_dv), .dout(dout),
    .dout_dv(dout_dv), .dout_rdy(dout_rdy), .sof(sof), .eof(eof), .ovf(ovf)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { int start; bit chk; } frm_t;
  typedef struct { int d; int y; } vec_t;

  int   ys[$];
  frm_t exp_q[$];
  int   xp_m = 0;
  int   ns = 0;
  int   rdy_mode = 0;
  vec_t tbl [10];
  logic signed [15:0] cap [FL];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pre-emphasis on plain integers
  function automatic int pe_ref(input int d, input int xp);
    int t;
    t = d - xp + (xp >>> 5);
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  task automatic send(input int d);
    frm_t f;
    din    = 16'(d);
    din_dv = 1'b1;
    ys.push_back(pe_ref(d, xp_m));
    xp_m = d;
    ns++;
    if (ns >= FL && ((ns - FL) % HP) == 0) begin
      f.start = ns - FL;
      f.chk   = 1'b1;
      exp_q.push_back(f);
    end
    @(posedge clk); #1;
    din_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_model();
    exp_q.delete();
    ys.delete();
    xp_m = 0;
    ns   = 0;
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    din_dv = 1'b0;
    clear_model();
    idle(3);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic wait_sof(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (dout_dv && sof) begin ok = 1'b1; break; end
    end
    check("sof_seen", ok, 1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || dout_dv) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_frames_left", exp_q.size(), 0);
  endtask

  // Consumer-ready pattern
  initial begin
    dout_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       dout_rdy = 1'b1;
        1:       dout_rdy = ($urandom_range(0, 3) != 0);
        default: dout_rdy = 1'b0;
      endcase
    end
  end

  // Transfer monitor: framing, data order and stall stability
  initial begin
    int widx = 0;
    int cur_start = -1;
    bit cur_chk = 1'b0;
    bit pstall = 1'b0;
    logic signed [15:0] pd;
    logic ps, pev;
    forever begin
      @(negedge clk);
      if (!reset) begin
        widx   = 0;
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          check("stall_dv", dout_dv, 1);
          check("stall_data", dout, pd);
          check("stall_sof", sof, ps);
          check("stall_eof", eof, pev);
        end
        pstall = dout_dv && !dout_rdy;
        pd = dout; ps = sof; pev = eof;
        if (dout_dv && dout_rdy) begin
          if (widx == 0) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_frame: got a frame start expected none (t=%0t)", $time);
              cur_start = -1; cur_chk = 1'b0;
            end else begin
              cur_start = exp_q[0].start;
              cur_chk   = exp_q[0].chk;
            end
          end
          check("sof", sof, widx == 0);
          check("eof", eof, widx == FL - 1);
          if (cur_chk) check("data", dout, ys[cur_start + widx]);
          cap[widx] = dout;
          if (widx == FL - 1) begin
            widx = 0;
            if (cur_start >= 0 && exp_q.size() > 0) void'(exp_q.pop_front());
          end else begin
            widx++;
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    frm_t f;
    tbl[0] = '{1000, 1000};
    tbl[1] = '{1000, 31};
    tbl[2] = '{1000, 31};
    tbl[3] = '{32767, 31798};
    tbl[4] = '{-32768, -32768};
    tbl[5] = '{32767, 32767};
    tbl[6] = '{0, -31744};
    tbl[7] = '{-5, -5};
    tbl[8] = '{-5, -1};
    tbl[9] = '{100, 104};

    reset = 1'b0; din = '0; din_dv = 1'b0;
    idle(3);
    check("rst_dout", dout, 0);
    check("rst_dv", dout_dv, 0);
    check("rst_sof", sof, 0);
    check("rst_eof", eof, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;
    idle(1);

    // Table vectors lead the first frame, then a ramp fills it
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) send(tbl[i].d);
    for (int i = 10; i < FL; i++) send(i * 64 - 8000);
    wait_sof(50);
    cnt = 1;
    repeat (FL - 1) begin
      @(negedge clk);
      if (dout_dv && dout_rdy) cnt++;
    end
    check("contiguous_words", cnt, FL);
    @(posedge clk); #1;
    idle(5);
    for (int i = 0; i < 10; i++) check($sformatf("table_y[%0d]", i), cap[i], tbl[i].y);
    check("f1_eof_word", cap[FL-1], ys[FL-1]);

    for (int i = 0; i < HP; i++) send(3000 - i * 17);
    wait_drain(2000);
    check("f2_word0", cap[0], ys[128]);

    // Randomized traffic with random backpressure
    rdy_mode = 1;
    repeat (1200) begin
      send(int'($urandom_range(0, 65535)) - 32768);
      idle($urandom_range(4, 9));
    end
    wait_drain(5000);
    check("random_no_ovf", ovf, 0);

    // Backpressure across three hops: one pending frame kept, later ones dropped
    apply_reset();
    rdy_mode = 2;
    idle(2);
    for (int i = 0; i < FL + 3 * HP; i++) send((i * 37) % 20000 - 10000);
    idle(5);
    check("hold_ovf", ovf, 1);
    check("hold_dv", dout_dv, 1);
    check("hold_sof", sof, 1);
    check("hold_word0", dout, ys[0]);
    check("hold_queue", exp_q.size(), 4);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    f = exp_q.pop_front();
    f.chk = 1'b0;
    exp_q.push_front(f);
    rdy_mode = 0;
    wait_drain(2000);
    check("pending_word0", cap[0], ys[128]);
    idle(50);
    check("no_extra_frame", dout_dv, 0);

    // Reset mid-stream aborts output; restart needs a full frame of new samples
    apply_reset();
    check("rst2_ovf", ovf, 0);
    for (int i = 0; i < FL; i++) send(i * 5 - 600);
    wait_sof(50);
    repeat (100) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_dv", dout_dv, 0);
    check("abort_sof", sof, 0);
    check("abort_eof", eof, 0);
    clear_model();
    @(posedge clk); #1;
    idle(2);
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < FL - 1; i++) send(700 - i * 3);
    idle(20);
    check("no_early_frame", dout_dv, 0);
    send(123);
    wait_drain(1000);
    check("restart_word0", cap[0], ys[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
